// File: rtl/mux_serial_adder_if.sv
// Operand/result bundle for mux_serial_adder.
//   in_valid/in_ready   : operand handshake (a, b, cin, sub travel with it)
//   out_valid/out_ready : result handshake (sum, cout, ovf travel with it)
//   busy                : adder is working on or holding a result
// The master modport is the side that supplies operands and consumes
// results; the slave modport is the adder itself.
interface mux_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/mux_serial_adder.sv
// Digit-serial adder/subtractor built from mux-based full-adder slices.
// Each slice is a pair of 4:1 muxes selected by {a_bit, b_bit}; the sum mux
// picks c/~c/~c/c and the carry mux picks 0/c/c/1. DIGIT slices are chained
// per clock, LSB digit first, so an operation takes WIDTH/DIGIT RUN cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of mux_serial_adder_if (operand/result handshakes,
//          a, b, cin, sub in; sum, cout, ovf, busy out)
// Subtraction is a + ~b + ~cin, so cout = 1 means "no borrow".
module mux_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic              clk,
  input logic              rst,
  mux_serial_adder_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             cout_reg;
  logic             ovf_reg;
  logic [CW-1:0]    count;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] s_dig;
  logic [DIGIT:0]   c_chain;
  logic             last;

  // One mux full-adder slice; returns {carry_out, sum}.
  function automatic logic [1:0] mux_fa(input logic x, input logic y, input logic c);
    logic [1:0] r;
    case ({x, y})
      2'b00:   r = {1'b0, c};
      2'b01:   r = {c, ~c};
      2'b10:   r = {c, ~c};
      default: r = {1'b1, c};
    endcase
    return r;
  endfunction

  assign last = (count == CW'(NDIG - 1));

  // Select the current digit with constant slices so the result register
  // is only touched one digit at a time.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (count == CW'(d)) begin
        a_dig = a_reg[d*DIGIT +: DIGIT];
        b_dig = b_reg[d*DIGIT +: DIGIT];
      end
    end
  end

  always_comb begin
    c_chain    = '0;
    s_dig      = '0;
    c_chain[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      {c_chain[i+1], s_dig[i]} = mux_fa(a_dig[i], b_dig[i], c_chain[i]);
    end
  end

  always_comb begin
    sum_next = sum_reg;
    for (int d = 0; d < NDIG; d++) begin
      if (count == CW'(d)) begin
        sum_next[d*DIGIT +: DIGIT] = s_dig;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // There is deliberately no accept path out of DONE: the handoff cycle
  // always returns to IDLE first.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.cin ^ bus.sub;
            count <= '0;
          end
        end
        RUN: begin
          sum_reg <= sum_next;
          carry   <= c_chain[DIGIT];
          count   <= last ? '0 : count + CW'(1);
          if (last) begin
            // The last digit's top slice is the MSB of the word.
            cout_reg <= c_chain[DIGIT];
            ovf_reg  <= c_chain[DIGIT-1] ^ c_chain[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_mux_serial_adder.sv
// Directed and randomized bench for mux_serial_adder. Three instances
// (DIGIT = 1, 4, 8 at WIDTH = 8) share clock and reset; each is driven
// through its own interface from per-instance stimulus variables.
module tb_mux_serial_adder;

  logic clk;
  logic rst;

  logic       in_valid  [3];
  logic       out_ready [3];
  logic [7:0] a_in      [3];
  logic [7:0] b_in      [3];
  logic       cin_in    [3];
  logic       sub_in    [3];

  logic       in_ready_o  [3];
  logic       out_valid_o [3];
  logic [7:0] sum_o       [3];
  logic       cout_o      [3];
  logic       ovf_o       [3];
  logic       busy_o      [3];

  int compared;
  int mismatched;

  localparam int LAT [3] = '{8, 2, 1};

  mux_serial_adder_if #(.WIDTH(8)) bus0 ();
  mux_serial_adder_if #(.WIDTH(8)) bus1 ();
  mux_serial_adder_if #(.WIDTH(8)) bus2 ();

  mux_serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mux_serial_adder #(.WIDTH(8), .DIGIT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux_serial_adder #(.WIDTH(8), .DIGIT(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.in_valid = in_valid[0];  assign bus0.out_ready = out_ready[0];
  assign bus0.a = a_in[0];  assign bus0.b = b_in[0];
  assign bus0.cin = cin_in[0];  assign bus0.sub = sub_in[0];
  assign in_ready_o[0] = bus0.in_ready;  assign out_valid_o[0] = bus0.out_valid;
  assign sum_o[0] = bus0.sum;  assign cout_o[0] = bus0.cout;
  assign ovf_o[0] = bus0.ovf;  assign busy_o[0] = bus0.busy;

  assign bus1.in_valid = in_valid[1];  assign bus1.out_ready = out_ready[1];
  assign bus1.a = a_in[1];  assign bus1.b = b_in[1];
  assign bus1.cin = cin_in[1];  assign bus1.sub = sub_in[1];
  assign in_ready_o[1] = bus1.in_ready;  assign out_valid_o[1] = bus1.out_valid;
  assign sum_o[1] = bus1.sum;  assign cout_o[1] = bus1.cout;
  assign ovf_o[1] = bus1.ovf;  assign busy_o[1] = bus1.busy;

  assign bus2.in_valid = in_valid[2];  assign bus2.out_ready = out_ready[2];
  assign bus2.a = a_in[2];  assign bus2.b = b_in[2];
  assign bus2.cin = cin_in[2];  assign bus2.sub = sub_in[2];
  assign in_ready_o[2] = bus2.in_ready;  assign out_valid_o[2] = bus2.out_valid;
  assign sum_o[2] = bus2.sum;  assign cout_o[2] = bus2.cout;
  assign ovf_o[2] = bus2.ovf;  assign busy_o[2] = bus2.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Waits for in_ready, presents one operand set, and scrambles the inputs
  // right after the accept edge so late sampling would be caught.
  task automatic applyStimulus(input int d, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic sub, input string tag);
    int n;
    n = 0;
    while (!in_ready_o[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, " in_ready"}, 32'(in_ready_o[d]), 32'd1);
    in_valid[d] = 1'b1;
    a_in[d]     = a;
    b_in[d]     = b;
    cin_in[d]   = cin;
    sub_in[d]   = sub;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    a_in[d]     = ~a;
    b_in[d]     = a ^ b;
    cin_in[d]   = ~cin;
    sub_in[d]   = ~sub;
    checkOutput({tag, " busy"}, 32'(busy_o[d]), 32'd1);
  endtask

  // Called 1 ns after the accept edge; counts edges until out_valid.
  task automatic wait_done(input int d, input logic [7:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (!out_valid_o[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " sum"}, 32'(sum_o[d]), 32'(exp_sum));
    checkOutput({tag, " cout"}, 32'(cout_o[d]), 32'(exp_cout));
    checkOutput({tag, " ovf"}, 32'(ovf_o[d]), 32'(exp_ovf));
  endtask

  task automatic release_result(input int d, input string tag);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    checkOutput({tag, " out_valid low"}, 32'(out_valid_o[d]), 32'd0);
    checkOutput({tag, " ready again"}, 32'(in_ready_o[d]), 32'd1);
  endtask

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [7:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf, input string name);
    string tag;
    tag = $sformatf("d%0d %s", d, name);
    applyStimulus(d, a, b, cin, sub, tag);
    wait_done(d, exp_sum, exp_cout, exp_ovf, LAT[d], tag);
    release_result(d, tag);
  endtask

  task automatic run_vectors(input int d);
    run_op(d, 8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, "add 3C+45");
    run_op(d, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "add FF+01+1");
    run_op(d, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "add 7F+00+1");
    run_op(d, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, "sub 10-20");
    run_op(d, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub 80-01");
  endtask

  initial begin
    logic [7:0] ra, rb, rsum, held;
    logic       rcin, rsub, rcout, rovf;
    int         sa, sb, sr, stall, d;
    logic [8:0] full;

    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      a_in[i] = '0; b_in[i] = '0; cin_in[i] = 1'b0; sub_in[i] = 1'b0;
    end

    // Reset state, observed while reset is still asserted.
    rst = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("d%0d reset in_ready", i), 32'(in_ready_o[i]), 32'd0);
      checkOutput($sformatf("d%0d reset out_valid", i), 32'(out_valid_o[i]), 32'd0);
      checkOutput($sformatf("d%0d reset busy", i), 32'(busy_o[i]), 32'd0);
      checkOutput($sformatf("d%0d reset sum", i), 32'(sum_o[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_vectors(0);

    // Backpressure: result must hold while the next request is ignored.
    applyStimulus(0, 8'h3C, 8'h45, 1'b0, 1'b0, "d0 bp first");
    wait_done(0, 8'h81, 1'b0, 1'b1, 8, "d0 bp first");
    in_valid[0] = 1'b1; b_in[0] = 8'h01; cin_in[0] = 1'b0; sub_in[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_in[0] = 8'(8'h11 * (k + 1));
      @(posedge clk); #1;
      checkOutput("d0 bp hold sum", 32'(sum_o[0]), 32'h81);
      checkOutput("d0 bp hold cout", 32'(cout_o[0]), 32'd0);
      checkOutput("d0 bp hold ovf", 32'(ovf_o[0]), 32'd1);
      checkOutput("d0 bp in_ready", 32'(in_ready_o[0]), 32'd0);
      checkOutput("d0 bp out_valid", 32'(out_valid_o[0]), 32'd1);
    end
    a_in[0] = 8'h80;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    checkOutput("d0 bp handoff out_valid", 32'(out_valid_o[0]), 32'd0);
    checkOutput("d0 bp handoff in_ready", 32'(in_ready_o[0]), 32'd1);
    checkOutput("d0 bp handoff busy", 32'(busy_o[0]), 32'd0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    checkOutput("d0 bp second accepted", 32'(busy_o[0]), 32'd1);
    wait_done(0, 8'h7F, 1'b1, 1'b1, 8, "d0 bp second");
    release_result(0, "d0 bp second");

    // Reset in the middle of RUN (count = 3) clears outputs immediately.
    applyStimulus(0, 8'hAA, 8'h55, 1'b0, 1'b0, "d0 abort");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("d0 abort pre busy", 32'(busy_o[0]), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("d0 abort sum", 32'(sum_o[0]), 32'd0);
    checkOutput("d0 abort cout", 32'(cout_o[0]), 32'd0);
    checkOutput("d0 abort ovf", 32'(ovf_o[0]), 32'd0);
    checkOutput("d0 abort busy", 32'(busy_o[0]), 32'd0);
    checkOutput("d0 abort out_valid", 32'(out_valid_o[0]), 32'd0);
    checkOutput("d0 abort in_ready", 32'(in_ready_o[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "after abort 01+01");

    run_vectors(1);
    run_vectors(2);

    // Random operations against an integer reference, with output stalls.
    for (int i = 0; i < 1000; i++) begin
      d    = i % 3;
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rcin = 1'($urandom);
      rsub = 1'($urandom);
      sa   = int'($signed(ra));
      sb   = int'($signed(rb));
      if (rsub) begin
        full  = {1'b0, ra} - {1'b0, rb} - 9'(rcin);
        rcout = ~full[8];
        sr    = sa - sb - int'(rcin);
      end else begin
        full  = {1'b0, ra} + {1'b0, rb} + 9'(rcin);
        rcout = full[8];
        sr    = sa + sb + int'(rcin);
      end
      rsum  = full[7:0];
      rovf  = (sr > 127) || (sr < -128);
      stall = int'($urandom_range(0, 3));
      applyStimulus(d, ra, rb, rcin, rsub, $sformatf("d%0d rand %0d", d, i));
      wait_done(d, rsum, rcout, rovf, LAT[d], $sformatf("d%0d rand %0d", d, i));
      held = rsum;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        checkOutput($sformatf("d%0d rand %0d stall sum", d, i), 32'(sum_o[d]), 32'(held));
      end
      release_result(d, $sformatf("d%0d rand %0d", d, i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
